// File: rtl/act_skew_feeder_if.sv
// Loader- and array-facing signal bundle of the activation skew feeder.
// With FEEDER_STALL_CNT_EN defined the bundle also carries stall_cnt.
interface act_skew_feeder_if #(
    parameter int LANES = 4,
    parameter int DW    = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_vec;
    logic                in_last;
    logic [LANES*DW-1:0] out_a;
    logic                fire;
    logic                busy;
    logic                drain_done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    modport slave (
`ifdef FEEDER_STALL_CNT_EN
        output stall_cnt,
`endif
        input  in_valid, in_vec, in_last,
        output in_ready, out_a, fire, busy, drain_done
    );

    modport master (
`ifdef FEEDER_STALL_CNT_EN
        input  stall_cnt,
`endif
        output in_valid, in_vec, in_last,
        input  in_ready, out_a, fire, busy, drain_done
    );
endinterface

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and feeds them to the PE array with lane i delayed
// i fire-cycles; zero-flushes the skew tail per tile. Option: FEEDER_STALL_CNT_EN.
module act_skew_feeder #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    act_skew_feeder_if.slave   feed_io
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                fire_q, drain_done_q;
    logic                pop, flush, fire_d, push, full, empty;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic [LANES*DW-1:0] fifo_vec_q [DEPTH];
    logic                fifo_last_q [DEPTH];
    logic [LANES*DW-1:0] src_vec;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = feed_io.in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_vec_q[wr_ptr_q]  <= feed_io.in_vec;
            fifo_last_q[wr_ptr_q] <= feed_io.in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // IDLE pops like STREAM so a tile starts without a wasted cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (fifo_last_q[rd_ptr_q]) begin
                        if (LANES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = CW'(LANES - 1);
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE:    state_d = empty ? IDLE : STREAM;
            default: state_d = IDLE;
        endcase
    end

    assign fire_d  = pop || flush;
    assign src_vec = flush ? '0 : fifo_vec_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fire_q       <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fire_q       <= fire_d;
            drain_done_q <= (state_q == DONE);
        end
    end

    // Lane i: i skew stages, then the out_a register; everything advances only on fire.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DW-1:0] lane_q;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         lane_q <= '0;
                else if (fire_d) lane_q <= src_vec[0 +: DW];
            end
        end else begin : g_skew
            logic [DW-1:0] skew_q [gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < gi; k++) skew_q[k] <= '0;
                    lane_q <= '0;
                end else if (fire_d) begin
                    skew_q[0] <= src_vec[gi*DW +: DW];
                    for (int k = 1; k < gi; k++) skew_q[k] <= skew_q[k-1];
                    lane_q <= skew_q[gi-1];
                end
            end
        end
        assign feed_io.out_a[gi*DW +: DW] = lane_q;
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (drain_done_q)
            stall_cnt_q <= '0;
        else if (state_q == STREAM && empty && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end
    assign feed_io.stall_cnt = stall_cnt_q;
`endif

    assign feed_io.in_ready   = !full;
    assign feed_io.fire       = fire_q;
    assign feed_io.busy       = (state_q != IDLE) || !empty;
    assign feed_io.drain_done = drain_done_q;
endmodule
